// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

   // Transaction FSM: arbitrate in IDLE/RESP, drive memory in ACCESS.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   // Port identifiers, also used as the grant/last-winner encoding.
   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

   // Default cap on consecutive locked debug-port grants while the CPU waits.
   localparam int LOCK_MAX_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection between the CPU port (0) and debug port (1).
// Round-robin on ties, unless the debug port holds an unexpired lock.
module arb_pick
   import mem_arb_pkg::*;
#(
   parameter int LOCK_MAX = LOCK_MAX_DEF,
   parameter int CNT_W    = $clog2(LOCK_MAX + 1)
) (
   input  logic             req0,
   input  logic             req1,
   input  logic             last,
   input  logic             lock_active,
   input  logic [CNT_W-1:0] lock_cnt,
   output logic             gnt_vld,
   output logic             win
);

   // Pick the winner; a saturated lock falls back to the CPU port.
   always_comb begin
      gnt_vld = req0 | req1;
      win     = PORT_CPU;
      if (req0 && req1) begin
         if (lock_active)
            win = (lock_cnt < CNT_W'(LOCK_MAX)) ? PORT_DBG : PORT_CPU;
         else
            win = ~last;
      end else if (req1) begin
         win = PORT_DBG;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the unified instruction/data memory.
// One single-beat transaction per grant: ACCESS drives the memory for a
// cycle, RESP returns data/ack. All outputs decode from registered state.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int LOCK_MAX = LOCK_MAX_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   input  logic              lock1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(LOCK_MAX + 1);

   state_t             state;
   logic               sel;        // port being served
   logic               last;       // port granted most recently
   logic               lock_prev;  // last grant was port 1 with lock1 set
   logic [CNT_W-1:0]   lock_cnt;
   logic               lat_we;
   logic [ADDR_W-1:0]  lat_addr;
   logic [DATA_W-1:0]  lat_wdata;
   logic [DATA_W-1:0]  rdata_q;
   logic               pick_vld;
   logic               pick_win;
   logic               arb_en;
   logic               do_grant;
   logic               in_acc;
   logic               in_rsp;

   arb_pick #(
      .LOCK_MAX (LOCK_MAX),
      .CNT_W    (CNT_W)
   ) u_pick (
      .req0        (req0),
      .req1        (req1),
      .last        (last),
      .lock_active (lock_prev),
      .lock_cnt    (lock_cnt),
      .gnt_vld     (pick_vld),
      .win         (pick_win)
   );

   // Requests are only looked at between transactions.
   assign arb_en   = (state == S_IDLE) || (state == S_RESP);
   assign do_grant = arb_en && pick_vld;

   // Transaction sequencing.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE,
            S_RESP:   state <= pick_vld ? S_ACCESS : S_IDLE;
            S_ACCESS: state <= S_RESP;
            default:  state <= S_IDLE;
         endcase
      end
   end

   // Latch the winner's request fields and update the round-robin pointer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sel       <= PORT_CPU;
         last      <= PORT_DBG;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (do_grant) begin
         sel       <= pick_win;
         last      <= pick_win;
         lat_we    <= pick_win ? we1    : we0;
         lat_addr  <= pick_win ? addr1  : addr0;
         lat_wdata <= pick_win ? wdata1 : wdata0;
      end
   end

   // Debug-port lock bookkeeping; counts only grants that made the CPU wait.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lock_prev <= 1'b0;
         lock_cnt  <= '0;
      end else if (do_grant) begin
         if (pick_win == PORT_CPU) begin
            lock_prev <= 1'b0;
            lock_cnt  <= '0;
         end else begin
            lock_prev <= lock1;
            if (!lock1)
               lock_cnt <= '0;
            else if (req0 && (lock_cnt != CNT_W'(LOCK_MAX)))
               lock_cnt <= lock_cnt + CNT_W'(1);
         end
      end
   end

   // Capture read data at the end of ACCESS; writes respond with zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         rdata_q <= '0;
      else if (state == S_ACCESS)
         rdata_q <= lat_we ? '0 : mem_rdata;
   end

   // Output decode from registered state only.
   assign in_acc    = (state == S_ACCESS);
   assign in_rsp    = (state == S_RESP);
   assign gnt0      = in_acc && (sel == PORT_CPU);
   assign gnt1      = in_acc && (sel == PORT_DBG);
   assign rvalid0   = in_rsp && (sel == PORT_CPU);
   assign rvalid1   = in_rsp && (sel == PORT_DBG);
   assign rdata0    = rvalid0 ? rdata_q : '0;
   assign rdata1    = rvalid1 ? rdata_q : '0;
   assign mem_addr  = in_acc ? lat_addr  : '0;
   assign mem_wdata = in_acc ? lat_wdata : '0;
   assign mem_read  = in_acc && !lat_we;
   assign mem_write = in_acc &&  lat_we;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table-driven winner selection plus
// hand-written multi-cycle sequences against a small memory model.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LM = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          req0, req1, we0, we1, lock1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write;
   logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;

   // stand-alone picker for the truth table
   logic       p_r0, p_r1, p_last, p_lka, p_vld, p_win;
   logic [2:0] p_cnt;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .lock1(lock1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
   );

   arb_pick #(.LOCK_MAX(LM), .CNT_W(3)) u_pick (
      .req0(p_r0), .req1(p_r1), .last(p_last), .lock_active(p_lka),
      .lock_cnt(p_cnt), .gnt_vld(p_vld), .win(p_win)
   );

   // memory model: 64 words, combinational read, write on clock edge
   logic [DW-1:0] mem [0:63];
   logic          mem_init = 1'b0;
   assign mem_rdata = mem[mem_addr[7:2]];
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= '0;
         mem[4]   <= 32'hDEADBEEF;
         mem[5]   <= 32'hCAFEF00D;
         mem_init <= 1'b1;
      end else if (mem_write) begin
         mem[mem_addr[7:2]] <= mem_wdata;
      end
   end

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   typedef struct {
      logic       r0, r1, last, lka;
      logic [2:0] cnt;
      logic       vld, win;
   } pv_t;

   pv_t pv[10];
   int  exp_ord[9];
   int  ord[9];

   initial begin
      int rem0, rem1, ng, rv0, rv1, both, first_g, last_g, bad;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

      // ---- winner selection truth table
      pv[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
      pv[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0};
      pv[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1};
      pv[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0};
      pv[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1};
      pv[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1};
      pv[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1};
      pv[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0};
      pv[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1};
      pv[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0};
      for (int i = 0; i < 10; i++) begin
         p_r0 = pv[i].r0; p_r1 = pv[i].r1; p_last = pv[i].last;
         p_lka = pv[i].lka; p_cnt = pv[i].cnt;
         #1;
         chk($sformatf("pick[%0d] vld", i), p_vld, pv[i].vld);
         chk($sformatf("pick[%0d] win", i), p_win, pv[i].win);
      end

      // ---- reset state
      @(negedge clk);
      chk("rst strobes", {gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write}, 0);
      chk("rst rdata0", rdata0, 0);
      chk("rst rdata1", rdata1, 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst mem_wdata", mem_wdata, 0);
      reset = 1;

      // ---- single read
      req0 = 1; we0 = 0; addr0 = 32'h10;
      @(negedge clk);
      chk("rd gnt0", gnt0, 1);
      chk("rd gnt1", gnt1, 0);
      chk("rd mem_read", mem_read, 1);
      chk("rd mem_write", mem_write, 0);
      chk("rd mem_addr", mem_addr, 32'h10);
      chk("rd early rvalid0", rvalid0, 0);
      req0 = 0;
      @(negedge clk);
      chk("rd rvalid0", rvalid0, 1);
      chk("rd rdata0", rdata0, 32'hDEADBEEF);
      chk("rd gnt0 off", gnt0, 0);
      chk("rd mem_read off", mem_read, 0);
      @(negedge clk);
      chk("rd rvalid0 off", rvalid0, 0);

      // ---- tie after reset: port 0 first, port 1 two cycles later
      reset = 0; @(negedge clk); reset = 1;
      req0 = 1; req1 = 1; addr0 = 32'h10; addr1 = 32'h14;
      @(negedge clk);
      chk("tie gnt0", gnt0, 1);
      chk("tie gnt1 off", gnt1, 0);
      req0 = 0;
      @(negedge clk);
      chk("tie rvalid0", rvalid0, 1);
      chk("tie rdata0", rdata0, 32'hDEADBEEF);
      chk("tie rvalid1 off", rvalid1, 0);
      chk("tie rdata1 off", rdata1, 0);
      @(negedge clk);
      chk("tie gnt1", gnt1, 1);
      chk("tie mem_addr1", mem_addr, 32'h14);
      req1 = 0;
      @(negedge clk);
      chk("tie rvalid1", rvalid1, 1);
      chk("tie rdata1", rdata1, 32'hCAFEF00D);
      chk("tie rdata0 off", rdata0, 0);
      @(negedge clk);

      // ---- write on port 1, then back-to-back read on port 0
      req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'h12345678;
      @(negedge clk);
      chk("wr gnt1", gnt1, 1);
      chk("wr mem_write", mem_write, 1);
      chk("wr mem_read", mem_read, 0);
      chk("wr mem_wdata", mem_wdata, 32'h12345678);
      req1 = 0; we1 = 0;
      req0 = 1; we0 = 0; addr0 = 32'h20;
      @(negedge clk);
      chk("wr rvalid1", rvalid1, 1);
      chk("wr rdata1", rdata1, 0);
      @(negedge clk);
      chk("wr-rd gnt0", gnt0, 1);
      chk("wr-rd mem_addr", mem_addr, 32'h20);
      req0 = 0;
      @(negedge clk);
      chk("wr-rd rvalid0", rvalid0, 1);
      chk("wr-rd rdata0", rdata0, 32'h12345678);
      @(negedge clk);

      // ---- locked burst: port 0 x3, port 1 x6 with lock1
      reset = 0; @(negedge clk); reset = 1;
      exp_ord = '{0, 1, 1, 1, 1, 0, 1, 1, 0};
      rem0 = 3; rem1 = 6; ng = 0; rv0 = 0; rv1 = 0; both = 0;
      first_g = -1; last_g = -1;
      addr0 = 32'h10; addr1 = 32'h14; lock1 = 1;
      req0 = 1; req1 = 1;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         if (gnt0 && gnt1) both++;
         if (rvalid0) rv0++;
         if (rvalid1) rv1++;
         if (gnt0 || gnt1) begin
            if (ng < 9) ord[ng] = gnt1 ? 1 : 0;
            if (first_g < 0) first_g = c;
            last_g = c;
            ng++;
            if (gnt0 && rem0 > 0) rem0--;
            if (gnt1 && rem1 > 0) rem1--;
         end
         req0 = (rem0 > 0);
         req1 = (rem1 > 0);
      end
      lock1 = 0;
      chk("lock grant count", ng, 9);
      for (int i = 0; i < 9; i++)
         chk($sformatf("lock order[%0d]", i), ord[i], exp_ord[i]);
      chk("lock span", last_g - first_g, 16);
      chk("lock rvalid0 count", rv0, 3);
      chk("lock rvalid1 count", rv1, 6);
      chk("lock dual grant", both, 0);

      // ---- reset asserted during ACCESS of a write
      req1 = 1; we1 = 1; addr1 = 32'h30; wdata1 = 32'h55AA55AA;
      @(negedge clk);
      chk("rstw mem_write before", mem_write, 1);
      reset = 0; req1 = 0; we1 = 0;
      #1;
      chk("rstw mem_write", mem_write, 0);
      chk("rstw gnt1", gnt1, 0);
      chk("rstw mem_addr", mem_addr, 0);
      @(negedge clk);
      reset = 1;
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (rvalid0 || rvalid1 || gnt0 || gnt1 || mem_write || mem_read) bad++;
      end
      chk("rstw no response", bad, 0);
      req0 = 1; req1 = 1; we0 = 0; addr0 = 32'h30; addr1 = 32'h14;
      @(negedge clk);
      chk("rstw tie gnt0", gnt0, 1);
      chk("rstw tie gnt1", gnt1, 0);
      req0 = 0; req1 = 0;
      @(negedge clk);
      chk("rstw write abandoned", rdata0, 0);
      @(negedge clk);

      // ---- idle
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (gnt0 || gnt1 || rvalid0 || rvalid1 || mem_read || mem_write) bad++;
      end
      chk("idle outputs", bad, 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
